// File: rtl/des_pkg.sv
// DES tables, permutation helpers and FSM state type shared by the decrypt datapath.
// Latency: none (package). Backpressure: none (package).
// Bit 0 is the MSB everywhere; tables keep the 1-based DES numbering.
package des_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    localparam int SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    // Right-rotate applied before decrypt round i+1 undoes encrypt round 17-i's left shift.
    localparam int REV_ROT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [0:63] ip(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[IP_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [0:63] fp(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[FP_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [0:47] e_exp(input logic [0:31] x);
        logic [0:47] y;
        for (int i = 0; i < 48; i++) y[i] = x[E_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [0:31] p_perm(input logic [0:31] x);
        logic [0:31] y;
        for (int i = 0; i < 32; i++) y[i] = x[P_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [0:55] pc1(input logic [0:63] x);
        logic [0:55] y;
        for (int i = 0; i < 56; i++) y[i] = x[PC1_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [0:47] pc2(input logic [0:55] x);
        logic [0:47] y;
        for (int i = 0; i < 48; i++) y[i] = x[PC2_TBL[i] - 1];
        return y;
    endfunction

    // Row is the outer bit pair of each 6-bit group, column the inner four.
    function automatic logic [0:31] sbox_layer(input logic [0:47] x);
        logic [0:31] y;
        logic [0:5]  b;
        for (int i = 0; i < 8; i++) begin
            b = x[6*i +: 6];
            y[4*i +: 4] = 4'(SBOX[i][{b[0], b[5], b[1:4]}]);
        end
        return y;
    endfunction

endpackage

// File: rtl/des_key_sched_rev.sv
// Reverse DES key schedule step: right-rotates C/D for the given decrypt round, emits its subkey.
// Latency: combinational. Backpressure: none.
// Round index 0 (K16) applies no rotation; the rotated halves feed the next step.
module des_key_sched_rev
    import des_pkg::*;
(
    input  logic [0:27] c,
    input  logic [0:27] d,
    input  logic [3:0]  round_idx,
    output logic [0:27] c_next,
    output logic [0:27] d_next,
    output logic [0:47] subkey
);

    int rot;

    always_comb begin
        rot    = REV_ROT[round_idx];
        c_next = (c >> rot) | (c << (28 - rot));
        d_next = (d >> rot) | (d << (28 - rot));
        subkey = pc2({c_next, d_next});
    end

endmodule

// File: rtl/des_round_f.sv
// DES Feistel f-function: E-expansion, key XOR, S-boxes, P permutation.
// Latency: combinational. Backpressure: none.
// One instance per unrolled round.
module des_round_f
    import des_pkg::*;
(
    input  logic [0:31] r,
    input  logic [0:47] k,
    output logic [0:31] f
);

    assign f = p_perm(sbox_layer(e_exp(r) ^ k));

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: ROUNDS_PER_CYCLE Feistel rounds per clock, subkeys K16..K1.
// Latency: 16/ROUNDS_PER_CYCLE cycles from accept to out_valid; one job in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_data,
    input  logic [0:63] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_data,
    output logic        busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
        $error("des_decrypt_iter: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         CYCLES   = 16 / ROUNDS_PER_CYCLE;
    localparam logic [3:0] LAST_CNT = 4'(CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [0:31] l_q, r_q;
    logic [0:27] c_q, d_q;
    logic [0:63] out_data_q;
    logic        out_valid_q;
    logic [0:63] ip_in;
    logic [0:55] pc1_key;

    logic [0:31] l_s [ROUNDS_PER_CYCLE+1];
    logic [0:31] r_s [ROUNDS_PER_CYCLE+1];
    logic [0:27] c_s [ROUNDS_PER_CYCLE+1];
    logic [0:27] d_s [ROUNDS_PER_CYCLE+1];
    logic [0:47] k_s [ROUNDS_PER_CYCLE];
    logic [0:31] f_s [ROUNDS_PER_CYCLE];

    assign ip_in   = ip(in_data);
    assign pc1_key = pc1(in_key);

    assign l_s[0] = l_q;
    assign r_s[0] = r_q;
    assign c_s[0] = c_q;
    assign d_s[0] = d_q;

    // Unrolled rounds share one cycle; key rotations chain through the same path.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [3:0] idx;
        assign idx = 4'(int'(cnt_q) * ROUNDS_PER_CYCLE + j);

        des_key_sched_rev u_ks (
            .c         (c_s[j]),
            .d         (d_s[j]),
            .round_idx (idx),
            .c_next    (c_s[j+1]),
            .d_next    (d_s[j+1]),
            .subkey    (k_s[j])
        );

        des_round_f u_f (
            .r (r_s[j]),
            .k (k_s[j]),
            .f (f_s[j])
        );

        assign l_s[j+1] = r_s[j];
        assign r_s[j+1] = l_s[j] ^ f_s[j];
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = ROUND;
            ROUND:   if (cnt_q == LAST_CNT)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q   <= ip_in[0:31];
                        r_q   <= ip_in[32:63];
                        c_q   <= pc1_key[0:27];
                        d_q   <= pc1_key[28:55];
                        cnt_q <= '0;
                    end
                end
                ROUND: begin
                    l_q   <= l_s[ROUNDS_PER_CYCLE];
                    r_q   <= r_s[ROUNDS_PER_CYCLE];
                    c_q   <= c_s[ROUNDS_PER_CYCLE];
                    d_q   <= d_s[ROUNDS_PER_CYCLE];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        // Final swap folded into the concatenation order.
                        out_data_q  <= fp({r_s[ROUNDS_PER_CYCLE], l_s[ROUNDS_PER_CYCLE]});
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter: known-answer vectors, stall, back-to-back, mid-job reset.
// A second instance with four rounds per cycle checks the unrolled latency.
module tb_des_decrypt_iter;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CT2 = 64'h0000000000000000;
    localparam logic [63:0] PT2 = 64'h8787878787878787;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] in_data, in_key, out_data;
    logic        in_valid4, in_ready4, out_valid4, busy4;
    logic        out_ready4;
    logic [63:0] out_data4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .busy      (busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one job, wait for accept, measure cycles to out_valid, then let it drain.
    task automatic run_job(input logic [63:0] ct, input logic [63:0] key,
                           output logic [63:0] pt, output int lat);
        in_data  = ct;
        in_key   = key;
        in_valid = 1'b1;
        lat      = 0;
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        pt = out_data;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 64'h0)  begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    endtask

    task automatic test_vector(input string name, input logic [63:0] ct, input logic [63:0] key,
                               input logic [63:0] exp);
        logic [63:0] pt;
        int lat;
        run_job(ct, key, pt, lat);
        checks++; if (pt !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", name, pt, exp); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL %s_latency: got %0d expected 16", name, lat); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL %s_drain: got out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready); end
    endtask

    task automatic test_parity_ignored();
        logic [63:0] key_par;
        key_par = K1 ^ 64'h0101010101010101;
        test_vector("parity", CT1, key_par, PT1);
    endtask

    task automatic test_stall();
        int waited = 0;
        int bad_vld = 0, bad_dat = 0, bad_rdy = 0;
        in_data = CT1; in_key = K1; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (!out_valid && waited < 100) begin tick(); waited++; end
        checks++; if (waited !== 16) begin errors++; $display("FAIL stall_latency: got %0d expected 16", waited); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1) bad_vld++;
            if (out_data !== PT1)   bad_dat++;
            if (in_ready !== 1'b0)  bad_rdy++;
            tick();
        end
        checks++; if (bad_vld !== 0) begin errors++; $display("FAIL stall_out_valid: got %0d dropped cycles expected 0", bad_vld); end
        checks++; if (bad_dat !== 0) begin errors++; $display("FAIL stall_out_data: got %0d changed cycles expected 0", bad_dat); end
        checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL stall_in_ready: got %0d high cycles expected 0", bad_rdy); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL stall_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        checks++; if (out_data !== PT1) begin errors++; $display("FAIL stall_hold_after: got %h expected %h", out_data, PT1); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got [2];
        int n = 0, gap = -1, cyc = 0;
        bit second = 1'b0;
        out_ready = 1'b1;
        in_data = CT1; in_key = K1; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        tick();
        in_data = CT2; in_key = K2;
        while (n < 2 && cyc < 80) begin
            if (out_valid) begin got[n] = out_data; n++; end
            if (in_ready && !second) begin second = 1'b1; gap = cyc + 1; end
            tick();
            cyc++;
            if (second) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (n !== 2)       begin errors++; $display("FAIL b2b_count: got %0d results expected 2", n); end
        checks++; if (gap !== 18)    begin errors++; $display("FAIL b2b_accept_gap: got %0d expected 18", gap); end
        checks++; if (got[0] !== PT1) begin errors++; $display("FAIL b2b_first: got %h expected %h", got[0], PT1); end
        checks++; if (got[1] !== PT2) begin errors++; $display("FAIL b2b_second: got %h expected %h", got[1], PT2); end
    endtask

    task automatic test_reset_mid_round();
        int rises = 0;
        in_data = CT1; in_key = K1; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL midrst_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) rises++;
            tick();
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", rises); end
        test_vector("after_rst", CT1, K1, PT1);
    endtask

    task automatic test_unroll4();
        int lat = 0;
        in_data = CT1; in_key = K1; in_valid4 = 1'b1;
        for (int i = 0; i < 40 && !in_ready4; i++) tick();
        tick();
        in_valid4 = 1'b0;
        while (!out_valid4 && lat < 100) begin tick(); lat++; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL unroll4_latency: got %0d expected 4", lat); end
        checks++; if (out_data4 !== PT1) begin errors++; $display("FAIL unroll4_data: got %h expected %h", out_data4, PT1); end
        tick();
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1)
            begin errors++; $display("FAIL unroll4_drain: got out_valid=%b in_ready=%b expected 0/1", out_valid4, in_ready4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid   = 1'b0;
        in_valid4  = 1'b0;
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
        in_data    = '0;
        in_key     = '0;
        test_reset();
        test_vector("vec1", CT1, K1, PT1);
        test_vector("vec2", CT2, K2, PT2);
        test_parity_ignored();
        test_stall();
        test_back_to_back();
        test_reset_mid_round();
        test_unroll4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
